mips_issue_wb: RTL and testbench

- Register-file plus issue/writeback sequencer that sits directly around the combinational MIPS execute core.
- Accepts one instruction at a time over a valid/ready handshake and reads the rs/rt operands from an internal 32x32 register file.
- Presents instruction and operands to the execute core, captures the returned result and writes it back to rd (R-type) or rt (I-type).
- Executes strictly one instruction at a time, so no forwarding or hazard logic is needed.

---
 rtl/mips_issue_wb_pkg.sv | 35 +++
 rtl/mips_regfile.sv | 30 +++
 rtl/mips_issue_wb.sv | 90 +++++++++
 tb/tb_mips_issue_wb.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mips_issue_wb_pkg.sv
// mips_issue_wb_pkg: opcodes, funct codes, field positions, FSM states and decode helpers
package mips_issue_wb_pkg;
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLTU = 6'd43;
    localparam int OP_HI = 31, OP_LO = 26;
    localparam int RS_HI = 25, RS_LO = 21;
    localparam int RT_HI = 20, RT_LO = 16;
    localparam int RD_HI = 15, RD_LO = 11;
    localparam int FN_HI = 5,  FN_LO = 0;
    typedef enum logic [1:0] {S_IDLE, S_OPERAND, S_EXEC, S_WRITE} state_e;
    function automatic logic is_legal(logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[OP_HI:OP_LO];
        fn = ins[FN_HI:FN_LO];
        return (op == OP_RTYPE)
            ? (fn inside {FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLTU})
            : (op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI});
    endfunction
    function automatic logic [4:0] dest_of(logic [31:0] ins);
        return (ins[OP_HI:OP_LO] == OP_RTYPE) ? ins[RD_HI:RD_LO] : ins[RT_HI:RT_LO];
    endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: register file with two operand read ports, a debug read port, one write port, r0 fixed at zero
module mips_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [4:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [4:0]        raddr_d,
    output logic [DATA_W-1:0] rdata_d
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    // clear everything on reset; writes to r0 are dropped so it always reads zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs_q[waddr] <= wdata;
        end
    end
    assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_q[raddr_b];
    assign rdata_d = (raddr_d == 5'd0) ? '0 : regs_q[raddr_d];
endmodule

// File: rtl/mips_issue_wb.sv
// mips_issue_wb: one-at-a-time issue/operand-fetch/writeback sequencer around the MIPS execute core
module mips_issue_wb
    import mips_issue_wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int DBG_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instruction,
    output logic [31:0]       alu_instruction,
    output logic [DATA_W-1:0] rs_content,
    output logic [DATA_W-1:0] rt_content,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [4:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_e            state_q, state_d;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] rs_q, rt_q, wbd_q, rs_rd, rt_rd, dbg_rd;
    logic [4:0]        dest_q;
    logic              legal_q;
    mips_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_valid),
        .waddr   (dest_q),
        .wdata   (wbd_q),
        .raddr_a (instr_q[RS_HI:RS_LO]),
        .rdata_a (rs_rd),
        .raddr_b (instr_q[RT_HI:RT_LO]),
        .rdata_b (rt_rd),
        .raddr_d (dbg_addr),
        .rdata_d (dbg_rd)
    );
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end
    // fixed four-step walk; only IDLE waits on the upstream handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = instr_valid ? S_OPERAND : S_IDLE;
            S_OPERAND: state_d = S_EXEC;
            S_EXEC:    state_d = S_WRITE;
            default:   state_d = S_IDLE;
        endcase
    end
    // handshake and one-cycle writeback/illegal pulses in WRITE
    always_comb begin
        instr_ready = state_q == S_IDLE;
        wb_valid    = state_q == S_WRITE && legal_q && dest_q != 5'd0;
        illegal     = state_q == S_WRITE && !legal_q;
    end
    // datapath captures: instruction on accept, operands and decode in OPERAND, result in EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dest_q  <= '0;
            legal_q <= 1'b0;
            wbd_q   <= '0;
        end else begin
            if (state_q == S_IDLE && instr_valid) instr_q <= instruction;
            if (state_q == S_OPERAND) begin
                rs_q    <= rs_rd;
                rt_q    <= rt_rd;
                dest_q  <= dest_of(instr_q);
                legal_q <= is_legal(instr_q);
            end
            if (state_q == S_EXEC) wbd_q <= alu_result;
        end
    end
    assign alu_instruction = instr_q;
    assign rs_content      = rs_q;
    assign rt_content      = rt_q;
    assign wb_reg          = dest_q;
    assign wb_data         = wbd_q;
    assign dbg_data        = (DBG_EN != 0) ? dbg_rd : '0;
endmodule

// File: tb/tb_mips_issue_wb.sv
// tb_mips_issue_wb: directed vectors with hand-computed expectations for the issue/writeback sequencer
module tb_mips_issue_wb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instruction = '0;
    logic [31:0] alu_instruction, rs_content, rt_content, alu_result, wb_data, dbg_data;
    logic        wb_valid, illegal;
    logic [4:0]  wb_reg;
    logic [4:0]  dbg_addr = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] prog [3];

    mips_issue_wb dut (
        .clk             (clk),
        .reset           (reset),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .alu_instruction (alu_instruction),
        .rs_content      (rs_content),
        .rt_content      (rt_content),
        .alu_result      (alu_result),
        .wb_valid        (wb_valid),
        .wb_reg          (wb_reg),
        .wb_data         (wb_data),
        .illegal         (illegal),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    always #5 clk = ~clk;

    // small execute-core model covering the operations used below
    always_comb begin
        alu_result = '0;
        case (alu_instruction[31:26])
            6'd0: begin
                if (alu_instruction[5:0] == 6'd32) alu_result = rs_content + rt_content;
                if (alu_instruction[5:0] == 6'd0)  alu_result = rt_content << alu_instruction[10:6];
            end
            6'd8:  alu_result = rs_content + {{16{alu_instruction[15]}}, alu_instruction[15:0]};
            6'd13: alu_result = rs_content | {16'b0, alu_instruction[15:0]};
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg r%0d", a), dbg_data, exp);
    endtask

    // one instruction through the four-cycle pipeline, checked at every stage
    task automatic run(input logic [31:0] ins, input logic [31:0] ers, input logic [31:0] ert,
                       input logic ewb, input logic [4:0] ereg, input logic [31:0] edata, input logic eill);
        @(negedge clk);
        instruction = ins;
        instr_valid = 1'b1;
        chk("ready idle", instr_ready, 1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ready operand", instr_ready, 0);
        @(negedge clk);
        chk("alu_instr exec", alu_instruction, ins);
        chk("rs exec", rs_content, ers);
        chk("rt exec", rt_content, ert);
        @(negedge clk);
        chk("wb_valid write", wb_valid, ewb);
        chk("illegal write", illegal, eill);
        if (ewb) begin
            chk("wb_reg", wb_reg, ereg);
            chk("wb_data", wb_data, edata);
        end
        @(negedge clk);
        chk("wb_valid after", wb_valid, 0);
        chk("illegal after", illegal, 0);
        chk("ready after", instr_ready, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("ready in reset", instr_ready, 1);
        chk("wb_valid in reset", wb_valid, 0);
        reset = 1'b0;
        chk("alu_instr reset", alu_instruction, 0);
        chk("wb_data reset", wb_data, 0);
        chk("wb_reg reset", wb_reg, 0);
        for (int i = 0; i < 32; i++) dbg(5'(i), 0);

        run(32'h20080005, 0, 0, 1, 8, 5, 0);
        dbg(8, 5);
        run(32'h01084820, 5, 5, 1, 9, 10, 0);
        dbg(9, 10);
        run(32'h20000007, 0, 0, 0, 0, 0, 0);
        dbg(0, 0);
        run(32'h08000000, 0, 0, 0, 0, 0, 1);
        dbg(8, 5);
        dbg(9, 10);
        run(32'h00094080, 0, 10, 1, 8, 40, 0);
        dbg(8, 40);
        run(32'h352E0003, 10, 0, 1, 14, 11, 0);
        dbg(14, 11);

        prog[0] = 32'h200B0001;
        prog[1] = 32'h200C0002;
        prog[2] = 32'h200D0003;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 4 == 0) instruction = prog[c / 4];
            instr_valid = (c <= 8);
            chk($sformatf("b2b ready c%0d", c), instr_ready, (c % 4 == 0));
        end
        @(negedge clk);
        instr_valid = 1'b0;
        dbg(11, 1);
        dbg(12, 2);
        dbg(13, 3);

        @(negedge clk);
        instruction = 32'h200A0009;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort ready", instr_ready, 1);
        chk("abort wb_valid", wb_valid, 0);
        chk("abort rs", rs_content, 0);
        chk("abort alu_instr", alu_instruction, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post-abort ready", instr_ready, 1);
        dbg(10, 0);
        dbg(8, 0);
        run(32'h200A0009, 0, 0, 1, 10, 9, 0);
        dbg(10, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
